t07_memory_sequencer: RTL and testbench
=======================================

# t07_memory_sequencer

Parametrised successor to the team's CPU memory handler. It sits between the t07 core and the MMIO/memory bus and sequences instruction fetch, then an optional load/store per instruction. It replaces busy-edge detection with a req/ack handshake and drives lane-aligned byte enables. It splits misaligned accesses into two bus beats and aborts stalled transactions on a timeout.

## Interface
Parameters:
- ADDR_W, default 32: address width.
- DATA_W, default 32: bus data width. Legal values are 32 and 64. BYTES = DATA_W/8.
- SPLIT_MISALIGNED, default 1: 1 splits boundary-crossing accesses into two beats; 0 faults them.
- TIMEOUT_CYC, default 255: maximum cycles a request waits for ack.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, synchronous, active-high.
- pc_i, in, ADDR_W: fetch address.
- memRead, memWrite, in, 1: data-phase request from the decoder.
- memOp, in, 4: operation code. 1=lb, 2=lh, 3=lw, 4=lbu, 5=lhu, 6=sb, 7=sh, 8=sw.
- memSource, in, 1: store data source. 1=FPU_data_i, 0=regData_i.
- ALU_address, in, ADDR_W: data address.
- FPU_data_i, regData_i, in, 32: store data.
- bus_req_o, out, 1: transaction request.
- bus_rwi_o, out, 2: transaction type. 11=fetch, 10=read, 01=write, 00=idle.
- bus_addr_o, out, ADDR_W: BYTES-aligned beat address.
- bus_be_o, out, BYTES: byte enables.
- bus_wdata_o, out, DATA_W: lane-shifted store data.
- bus_rdata_i, in, DATA_W: read data, valid with ack.
- bus_ack_i, in, 1: one-cycle completion strobe.
- instr_o, out, 32: last fetched instruction.
- regData_o, out, 32: extended load result.
- load_valid_o, out, 1: one-cycle pulse when regData_o is updated.
- freeze_o, out, 1: stalls the core.
- fault_o, out, 1: one-cycle fault pulse.
- fault_code_o, out, 2: fault cause. 1=misaligned (split disabled), 2=illegal op, 3=timeout. Holds its value until the next fault.
- state_o, out, 3: current state, for debug.

## Operation
- States: FETCH=0, F_WAIT=1, DATA=2, D_WAIT=3, D_WAIT2=4.
- Reset:
  - State goes to FETCH.
  - All outputs reset to 0, except bus_rwi_o=00.
  - All latches and the timeout counter clear.
- FETCH:
  - Latches pc_i rounded down to a BYTES boundary.
  - freeze_o=0, bus_req_o=0.
  - Next state: F_WAIT.
- F_WAIT:
  - Drives bus_req_o=1, bus_rwi_o=11, bus_be_o all ones.
  - On ack, latches instr_o from the 32-bit lane selected by pc_i[log2(BYTES)-1:2], then goes to DATA.
- DATA: evaluates memRead/memWrite and memOp.
  - Neither asserted: freeze_o=0, next state FETCH.
  - Both asserted, memRead with memOp outside 1..5, or memWrite with memOp outside 6..8: fault code 2, no bus access, next state FETCH.
  - Otherwise: compute size (1/2/4 bytes) and offset o = ALU_address mod BYTES, then latch address, o, size, op and store data.
  - If o+size ≤ BYTES: single beat, next state D_WAIT.
  - If o+size > BYTES and SPLIT_MISALIGNED=1: two beats, next state D_WAIT.
  - If o+size > BYTES and SPLIT_MISALIGNED=0: fault code 1, next state FETCH.
- Beat 0:
  - Address is ALU_address rounded down to a BYTES boundary.
  - bus_be_o has bits o..min(o+size, BYTES)-1 set.
  - bus_wdata_o is the store data shifted left by 8·o.
- Beat 1 (split accesses only, in D_WAIT2):
  - Address is beat 0 address + BYTES.
  - bus_be_o has bits 0..(o+size-BYTES)-1 set.
  - bus_wdata_o carries the remaining upper bytes at lane 0.
- D_WAIT / D_WAIT2:
  - bus_req_o=1; bus_rwi_o=10 for loads, 01 for stores.
  - On ack in D_WAIT: go to D_WAIT2 if split, otherwise FETCH. For split loads, beat 0 read data is held.
  - On ack in D_WAIT2: go to FETCH.
- Load completion:
  - Assemble bytes from the held beat 0 data and final-beat rdata.
  - Sign-extend for lb/lh, zero-extend for lbu/lhu.
  - Register into regData_o at the completing edge and pulse load_valid_o in the following FETCH cycle.
- freeze_o is 1 in F_WAIT, D_WAIT and D_WAIT2, and in DATA when a legal op is present. It is 0 in FETCH.
- Timeout:
  - The counter clears on entry to each *_WAIT state and increments every cycle without ack.
  - When it reaches TIMEOUT_CYC: fault code 3, drop the request, go to FETCH, leave regData_o unchanged.
- Ack arriving while bus_req_o=0 is ignored.

## Timing
- All state, latches and outputs update on the rising edge of clk.
- bus_req_o, bus_addr_o, bus_be_o and bus_wdata_o come from latched registers only. They are stable for the whole time bus_req_o is high.
- Ack is sampled on the rising edge. bus_req_o falls in the cycle after ack.
- Minimum latencies with ack in the first wait cycle:
  - Fetch only: 2 cycles (FETCH→F_WAIT→DATA).
  - Aligned load: 4 cycles, FETCH to the next FETCH.
  - Split load: 5 cycles.
- fault_o is asserted in the cycle after the decision (the first FETCH cycle).
- Ack and timeout expiry in the same cycle: ack wins, no fault.
- rst asserted in any state, including mid-transaction: at that edge, state goes to FETCH and bus_req_o=0 from the next cycle. The pending transaction is abandoned; no load_valid_o, no fault.

## Test plan
- Reset, then fetch pc_i=0x100 with ack after 3 cycles and rdata=0x00A00093 → instr_o=0x00A00093, state goes to DATA, freeze_o=0 afterwards.
- lb from 0x203 with rdata=0x80FFFFFF (DATA_W=32) → bus_be_o=1000, bus_addr_o=0x200, regData_o=0xFFFFFF80, load_valid_o pulses once.
- sw from 0x206 of 0xAABBCCDD, SPLIT_MISALIGNED=1 → beat 0: addr 0x204, be 1100, wdata 0xCCDD0000; beat 1: addr 0x208, be 0011, wdata 0x0000AABB.
- Same sw with SPLIT_MISALIGNED=0 → no bus request, fault_o pulses, fault_code_o=1, returns to FETCH.
- No ack with TIMEOUT_CYC=4 → request drops after 4 cycles, fault_code_o=3. Repeat with ack on cycle 4 → no fault.
- rst pulse during D_WAIT of a load → next cycle state_o=0, bus_req_o=0, load_valid_o stays 0, regData_o=0.

Source files
------------

// File: rtl/t07_memory_sequencer_if.sv
// t07_memory_sequencer_if
// Bus-side handshake bundle between the memory sequencer and the MMIO/memory bus.
//   master modport (sequencer): drives bus_req_o, bus_rwi_o, bus_addr_o, bus_be_o and
//                               bus_wdata_o; receives bus_rdata_i and bus_ack_i.
//   slave modport (bus/memory): the mirror image.
// bus_rwi_o encoding: 11=fetch, 10=read, 01=write, 00=idle.
interface t07_memory_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BYTES = DATA_W / 8;

  logic              bus_req_o;
  logic [1:0]        bus_rwi_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [BYTES-1:0]  bus_be_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_ack_i;

  modport master (
    output bus_req_o, bus_rwi_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_rdata_i, bus_ack_i
  );

  modport slave (
    input  bus_req_o, bus_rwi_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_rdata_i, bus_ack_i
  );
endinterface

// File: rtl/t07_memory_sequencer.sv
// t07_memory_sequencer
// Sequences an instruction fetch followed by an optional load/store for the t07 core,
// using a req/ack bus handshake with lane-aligned byte enables. Accesses that cross a
// bus-word boundary are either split into two beats or faulted. Stalled requests are
// abandoned after TIMEOUT_CYC cycles without ack.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   pc_i                      fetch address
//   memRead/memWrite/memOp    data-phase request and operation (1..5 loads, 6..8 stores)
//   memSource                 store data source (1=FPU_data_i, 0=regData_i)
//   ALU_address               data address
//   FPU_data_i, regData_i     store data candidates
//   bus                       bus handshake (master side)
//   instr_o                   last fetched instruction
//   regData_o, load_valid_o   extended load result and its one-cycle update pulse
//   freeze_o                  core stall
//   fault_o, fault_code_o     fault pulse and sticky cause (1=misaligned, 2=illegal, 3=timeout)
//   state_o                   current FSM state for debug
module t07_memory_sequencer #(
  parameter int ADDR_W           = 32,
  parameter int DATA_W           = 32,
  parameter int SPLIT_MISALIGNED = 1,
  parameter int TIMEOUT_CYC      = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     pc_i,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [3:0]            memOp,
  input  logic                  memSource,
  input  logic [ADDR_W-1:0]     ALU_address,
  input  logic [31:0]           FPU_data_i,
  input  logic [31:0]           regData_i,
  t07_memory_sequencer_if.master bus,
  output logic [31:0]           instr_o,
  output logic [31:0]           regData_o,
  output logic                  load_valid_o,
  output logic                  freeze_o,
  output logic                  fault_o,
  output logic [1:0]            fault_code_o,
  output logic [2:0]            state_o
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    F_WAIT  = 3'd1,
    DATA    = 3'd2,
    D_WAIT  = 3'd3,
    D_WAIT2 = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [OFF_W-1:0]    pc_off_q, pc_off_d;
  logic                req_q, req_d;
  logic [1:0]          rwi_q, rwi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTES-1:0]    be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr1_q, addr1_d;
  logic [BYTES-1:0]    be1_q, be1_d;
  logic [DATA_W-1:0]   wdata1_q, wdata1_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [2:0]          size_q, size_d;
  logic [3:0]          op_q, op_d;
  logic                split_q, split_d;
  logic                is_load_q, is_load_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         load_data_q, load_data_d;
  logic                load_valid_q, load_valid_d;
  logic                fault_q, fault_d;
  logic [1:0]          fault_code_q, fault_code_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Decode of the data-phase request presented in DATA.
  logic                legal_op;
  logic [2:0]          dec_size;
  logic [3:0]          be_base;
  logic [31:0]         store_mask;
  logic [31:0]         store_src;
  logic [OFF_W-1:0]    dec_off;
  logic                crosses;
  logic [ADDR_W-1:0]   dec_addr0;
  logic [2*BYTES-1:0]  wide_be;
  logic [2*DATA_W-1:0] wide_w;

  // Result assembly.
  logic                ack;
  logic                expired;
  logic [OFF_W-1:0]    lane_off;
  logic [DATA_W-1:0]   fetch_shifted;
  logic [2*DATA_W-1:0] wide_r;
  logic [2*DATA_W-1:0] load_shifted;
  logic [31:0]         load_raw;
  logic                load_signed;
  logic [31:0]         load_val;

  always_comb begin
    dec_size   = 3'd0;
    be_base    = 4'b0000;
    store_mask = 32'h0000_0000;
    case (memOp)
      4'd1, 4'd4, 4'd6: begin dec_size = 3'd1; be_base = 4'b0001; store_mask = 32'h0000_00FF; end
      4'd2, 4'd5, 4'd7: begin dec_size = 3'd2; be_base = 4'b0011; store_mask = 32'h0000_FFFF; end
      4'd3, 4'd8:       begin dec_size = 3'd4; be_base = 4'b1111; store_mask = 32'hFFFF_FFFF; end
      default:          begin dec_size = 3'd0; be_base = 4'b0000; store_mask = 32'h0000_0000; end
    endcase

    legal_op = 1'b0;
    if (memRead && !memWrite)
      legal_op = (memOp >= 4'd1) && (memOp <= 4'd5);
    else if (memWrite && !memRead)
      legal_op = (memOp >= 4'd6) && (memOp <= 4'd8);

    store_src = memSource ? FPU_data_i : regData_i;
    dec_off   = ALU_address[OFF_W-1:0];
    crosses   = ({2'b00, dec_off} + (OFF_W+2)'(dec_size)) > (OFF_W+2)'(BYTES);
    dec_addr0 = {ALU_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    // Shifting into a double-width word puts beat 0 in the low half and the
    // overflow (beat 1, starting at lane 0) in the high half.
    wide_be   = (2*BYTES)'(be_base) << dec_off;
    wide_w    = (2*DATA_W)'(store_src & store_mask) << {dec_off, 3'b000};
  end

  always_comb begin
    ack     = bus.bus_ack_i & req_q;
    expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Instruction lane: the 32-bit word of the bus beat addressed by pc.
    lane_off      = pc_off_q & OFF_W'(BYTES - 4);
    fetch_shifted = bus.bus_rdata_i >> {lane_off, 3'b000};

    wide_r       = split_q ? {bus.bus_rdata_i, rdata0_q} : {{DATA_W{1'b0}}, bus.bus_rdata_i};
    load_shifted = wide_r >> {off_q, 3'b000};
    load_raw     = load_shifted[31:0];
    load_signed  = (op_q == 4'd1) || (op_q == 4'd2);
    case (size_q)
      3'd1:    load_val = load_signed ? {{24{load_raw[7]}}, load_raw[7:0]} : {24'd0, load_raw[7:0]};
      3'd2:    load_val = load_signed ? {{16{load_raw[15]}}, load_raw[15:0]} : {16'd0, load_raw[15:0]};
      default: load_val = load_raw;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_off_d     = pc_off_q;
    req_d        = req_q;
    rwi_d        = rwi_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    addr1_d      = addr1_q;
    be1_d        = be1_q;
    wdata1_d     = wdata1_q;
    off_d        = off_q;
    size_d       = size_q;
    op_d         = op_q;
    split_d      = split_q;
    is_load_d    = is_load_q;
    rdata0_d     = rdata0_q;
    instr_d      = instr_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    fault_d      = 1'b0;
    fault_code_d = fault_code_q;
    cnt_d        = '0;

    case (state_q)
      FETCH: begin
        pc_off_d = pc_i[OFF_W-1:0];
        addr_d   = {pc_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        be_d     = '1;
        rwi_d    = 2'b11;
        req_d    = 1'b1;
        state_d  = F_WAIT;
      end

      F_WAIT: begin
        if (ack) begin
          instr_d = fetch_shifted[31:0];
          req_d   = 1'b0;
          rwi_d   = 2'b00;
          state_d = DATA;
        end else if (expired) begin
          req_d        = 1'b0;
          rwi_d        = 2'b00;
          fault_d      = 1'b1;
          fault_code_d = 2'd3;
          state_d      = FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (!memRead && !memWrite) begin
          state_d = FETCH;
        end else if (!legal_op) begin
          fault_d      = 1'b1;
          fault_code_d = 2'd2;
          state_d      = FETCH;
        end else if (crosses && (SPLIT_MISALIGNED == 0)) begin
          fault_d      = 1'b1;
          fault_code_d = 2'd1;
          state_d      = FETCH;
        end else begin
          off_d     = dec_off;
          size_d    = dec_size;
          op_d      = memOp;
          split_d   = crosses;
          is_load_d = memRead;
          addr_d    = dec_addr0;
          be_d      = wide_be[BYTES-1:0];
          wdata_d   = wide_w[DATA_W-1:0];
          addr1_d   = dec_addr0 + ADDR_W'(BYTES);
          be1_d     = wide_be[2*BYTES-1:BYTES];
          wdata1_d  = wide_w[2*DATA_W-1:DATA_W];
          rwi_d     = memRead ? 2'b10 : 2'b01;
          req_d     = 1'b1;
          state_d   = D_WAIT;
        end
      end

      D_WAIT, D_WAIT2: begin
        if (ack) begin
          if (state_q == D_WAIT && split_q) begin
            // Second beat: request stays high, counter restarts via default.
            rdata0_d = bus.bus_rdata_i;
            addr_d   = addr1_q;
            be_d     = be1_q;
            wdata_d  = wdata1_q;
            state_d  = D_WAIT2;
          end else begin
            if (is_load_q) begin
              load_data_d  = load_val;
              load_valid_d = 1'b1;
            end
            req_d   = 1'b0;
            rwi_d   = 2'b00;
            state_d = FETCH;
          end
        end else if (expired) begin
          req_d        = 1'b0;
          rwi_d        = 2'b00;
          fault_d      = 1'b1;
          fault_code_d = 2'd3;
          state_d      = FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        req_d   = 1'b0;
        rwi_d   = 2'b00;
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_off_q     <= '0;
      req_q        <= 1'b0;
      rwi_q        <= 2'b00;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      addr1_q      <= '0;
      be1_q        <= '0;
      wdata1_q     <= '0;
      off_q        <= '0;
      size_q       <= 3'd0;
      op_q         <= 4'd0;
      split_q      <= 1'b0;
      is_load_q    <= 1'b0;
      rdata0_q     <= '0;
      instr_q      <= 32'd0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'd0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_off_q     <= pc_off_d;
      req_q        <= req_d;
      rwi_q        <= rwi_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      addr1_q      <= addr1_d;
      be1_q        <= be1_d;
      wdata1_q     <= wdata1_d;
      off_q        <= off_d;
      size_q       <= size_d;
      op_q         <= op_d;
      split_q      <= split_d;
      is_load_q    <= is_load_d;
      rdata0_q     <= rdata0_d;
      instr_q      <= instr_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.bus_req_o   = req_q;
  assign bus.bus_rwi_o   = rwi_q;
  assign bus.bus_addr_o  = addr_q;
  assign bus.bus_be_o    = be_q;
  assign bus.bus_wdata_o = wdata_q;

  assign instr_o      = instr_q;
  assign regData_o    = load_data_q;
  assign load_valid_o = load_valid_q;
  assign fault_o      = fault_q;
  assign fault_code_o = fault_code_q;
  assign state_o      = state_q;

  // The core decides on a data access in the same DATA cycle it presents it, so the
  // stall has to follow memRead/memWrite/memOp combinationally there.
  assign freeze_o = (state_q == F_WAIT) || (state_q == D_WAIT) || (state_q == D_WAIT2) ||
                    ((state_q == DATA) && legal_op);
endmodule

// File: tb/tb_t07_memory_sequencer.sv
// Directed bench: dut_s splits misaligned accesses, dut_n faults them; both use a
// 4-cycle ack timeout and share the core-side inputs.
module tb_t07_memory_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, ALU_address, FPU_data_i, regData_i;
  logic        memRead, memWrite, memSource;
  logic [3:0]  memOp;

  logic [31:0] instr_s, rdo_s, instr_n, rdo_n;
  logic        lv_s, frz_s, flt_s, lv_n, frz_n, flt_n;
  logic [1:0]  fc_s, fc_n;
  logic [2:0]  st_s, st_n;

  int total = 0;
  int bad   = 0;

  t07_memory_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus_s ();
  t07_memory_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus_n ();

  t07_memory_sequencer #(.ADDR_W(32), .DATA_W(32), .SPLIT_MISALIGNED(1), .TIMEOUT_CYC(4)) dut_s (
    .clk(clk), .rst(rst), .pc_i(pc_i), .memRead(memRead), .memWrite(memWrite),
    .memOp(memOp), .memSource(memSource), .ALU_address(ALU_address),
    .FPU_data_i(FPU_data_i), .regData_i(regData_i), .bus(bus_s),
    .instr_o(instr_s), .regData_o(rdo_s), .load_valid_o(lv_s), .freeze_o(frz_s),
    .fault_o(flt_s), .fault_code_o(fc_s), .state_o(st_s)
  );

  t07_memory_sequencer #(.ADDR_W(32), .DATA_W(32), .SPLIT_MISALIGNED(0), .TIMEOUT_CYC(4)) dut_n (
    .clk(clk), .rst(rst), .pc_i(pc_i), .memRead(memRead), .memWrite(memWrite),
    .memOp(memOp), .memSource(memSource), .ALU_address(ALU_address),
    .FPU_data_i(FPU_data_i), .regData_i(regData_i), .bus(bus_n),
    .instr_o(instr_n), .regData_o(rdo_n), .load_valid_o(lv_n), .freeze_o(frz_n),
    .fault_o(flt_n), .fault_code_o(fc_n), .state_o(st_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pc_i = 32'h0; ALU_address = 32'h0; FPU_data_i = 32'h0; regData_i = 32'h0;
    memRead = 1'b0; memWrite = 1'b0; memSource = 1'b0; memOp = 4'd0;
    bus_s.bus_ack_i = 1'b0; bus_s.bus_rdata_i = 32'h0;
    bus_n.bus_ack_i = 1'b0; bus_n.bus_rdata_i = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_state", 32'(st_s), 32'd0);
    chk("rst_req", 32'(bus_s.bus_req_o), 32'd0);
    chk("rst_rwi", 32'(bus_s.bus_rwi_o), 32'd0);
    chk("rst_instr", instr_s, 32'h0);
    chk("rst_regdata", rdo_s, 32'h0);
    chk("rst_freeze", 32'(frz_s), 32'd0);
    chk("rst_fault", 32'(flt_s), 32'd0);
    chk("rst_fcode", 32'(fc_s), 32'd0);
    rst = 1'b0; pc_i = 32'h100;

    // Fetch from 0x100, ack in the third F_WAIT cycle
    tick();
    chk("fetch_state", 32'(st_s), 32'd1);
    chk("fetch_req", 32'(bus_s.bus_req_o), 32'd1);
    chk("fetch_rwi", 32'(bus_s.bus_rwi_o), 32'd3);
    chk("fetch_addr", bus_s.bus_addr_o, 32'h100);
    chk("fetch_be", 32'(bus_s.bus_be_o), 32'hF);
    chk("fetch_freeze", 32'(frz_s), 32'd1);
    tick(); tick();
    bus_s.bus_ack_i = 1'b1; bus_s.bus_rdata_i = 32'h00A00093;
    tick();
    bus_s.bus_ack_i = 1'b0;
    chk("fetch_done_state", 32'(st_s), 32'd2);
    chk("fetch_instr", instr_s, 32'h00A00093);
    chk("fetch_req_drop", 32'(bus_s.bus_req_o), 32'd0);
    chk("data_idle_freeze", 32'(frz_s), 32'd0);

    // lb from 0x203
    memRead = 1'b1; memOp = 4'd1; ALU_address = 32'h203;
    #1;
    chk("data_legal_freeze", 32'(frz_s), 32'd1);
    tick();
    memRead = 1'b0;
    chk("lb_state", 32'(st_s), 32'd3);
    chk("lb_addr", bus_s.bus_addr_o, 32'h200);
    chk("lb_be", 32'(bus_s.bus_be_o), 32'b1000);
    chk("lb_rwi", 32'(bus_s.bus_rwi_o), 32'd2);
    bus_s.bus_ack_i = 1'b1; bus_s.bus_rdata_i = 32'h80FFFFFF;
    tick();
    bus_s.bus_ack_i = 1'b0;
    chk("lb_back_fetch", 32'(st_s), 32'd0);
    chk("lb_regdata", rdo_s, 32'hFFFFFF80);
    chk("lb_valid", 32'(lv_s), 32'd1);
    chk("lb_req_drop", 32'(bus_s.bus_req_o), 32'd0);
    chk("fetch_state_freeze", 32'(frz_s), 32'd0);
    tick();
    chk("lb_valid_pulse", 32'(lv_s), 32'd0);

    // Fetch with immediate ack, then split sw from 0x206
    bus_s.bus_ack_i = 1'b1; bus_s.bus_rdata_i = 32'h12345678;
    tick();
    bus_s.bus_ack_i = 1'b0;
    chk("fetch2_instr", instr_s, 32'h12345678);
    memWrite = 1'b1; memOp = 4'd8; ALU_address = 32'h206; memSource = 1'b0; regData_i = 32'hAABBCCDD;
    tick();
    memWrite = 1'b0;
    chk("sw_b0_addr", bus_s.bus_addr_o, 32'h204);
    chk("sw_b0_be", 32'(bus_s.bus_be_o), 32'b1100);
    chk("sw_b0_wdata", bus_s.bus_wdata_o, 32'hCCDD0000);
    chk("sw_b0_rwi", 32'(bus_s.bus_rwi_o), 32'd1);
    bus_s.bus_ack_i = 1'b1;
    tick();
    chk("sw_b1_state", 32'(st_s), 32'd4);
    chk("sw_b1_req", 32'(bus_s.bus_req_o), 32'd1);
    chk("sw_b1_addr", bus_s.bus_addr_o, 32'h208);
    chk("sw_b1_be", 32'(bus_s.bus_be_o), 32'b0011);
    chk("sw_b1_wdata", bus_s.bus_wdata_o, 32'h0000AABB);
    tick();
    bus_s.bus_ack_i = 1'b0;
    chk("sw_done_state", 32'(st_s), 32'd0);
    chk("sw_no_valid", 32'(lv_s), 32'd0);
    chk("sw_no_fault", 32'(flt_s), 32'd0);

    // Fetch with no ack: drops after 4 wait cycles
    tick(); tick(); tick(); tick();
    chk("tmo_c4_req", 32'(bus_s.bus_req_o), 32'd1);
    chk("tmo_c4_state", 32'(st_s), 32'd1);
    tick();
    chk("tmo_req_drop", 32'(bus_s.bus_req_o), 32'd0);
    chk("tmo_state", 32'(st_s), 32'd0);
    chk("tmo_fault", 32'(flt_s), 32'd1);
    chk("tmo_fcode", 32'(fc_s), 32'd3);

    // Ack on the 4th wait cycle wins over expiry
    tick();
    chk("tmo_fault_pulse", 32'(flt_s), 32'd0);
    chk("fcode_sticky", 32'(fc_s), 32'd3);
    tick(); tick(); tick();
    bus_s.bus_ack_i = 1'b1; bus_s.bus_rdata_i = 32'h00000013;
    tick();
    bus_s.bus_ack_i = 1'b0;
    chk("ack4_state", 32'(st_s), 32'd2);
    chk("ack4_no_fault", 32'(flt_s), 32'd0);
    chk("ack4_instr", instr_s, 32'h00000013);

    // Split lh from 0x203
    memRead = 1'b1; memOp = 4'd2; ALU_address = 32'h203;
    tick();
    memRead = 1'b0;
    chk("lh_b0_be", 32'(bus_s.bus_be_o), 32'b1000);
    chk("lh_b0_addr", bus_s.bus_addr_o, 32'h200);
    bus_s.bus_ack_i = 1'b1; bus_s.bus_rdata_i = 32'hAB000000;
    tick();
    chk("lh_b1_state", 32'(st_s), 32'd4);
    chk("lh_b1_addr", bus_s.bus_addr_o, 32'h204);
    chk("lh_b1_be", 32'(bus_s.bus_be_o), 32'b0001);
    chk("lh_b1_no_valid", 32'(lv_s), 32'd0);
    bus_s.bus_rdata_i = 32'h000000CD;
    tick();
    bus_s.bus_ack_i = 1'b0;
    chk("lh_regdata", rdo_s, 32'hFFFFCDAB);
    chk("lh_valid", 32'(lv_s), 32'd1);

    // Illegal op: memRead with a store opcode
    tick();
    bus_s.bus_ack_i = 1'b1;
    tick();
    bus_s.bus_ack_i = 1'b0;
    memRead = 1'b1; memOp = 4'd7;
    #1;
    chk("illegal_freeze", 32'(frz_s), 32'd0);
    tick();
    memRead = 1'b0;
    chk("illegal_fault", 32'(flt_s), 32'd1);
    chk("illegal_fcode", 32'(fc_s), 32'd2);
    chk("illegal_no_req", 32'(bus_s.bus_req_o), 32'd0);

    // Reset in D_WAIT of a lw, with an ack present at the same edge
    tick();
    bus_s.bus_ack_i = 1'b1;
    tick();
    bus_s.bus_ack_i = 1'b0;
    memRead = 1'b1; memOp = 4'd3; ALU_address = 32'h300;
    tick();
    memRead = 1'b0;
    chk("rstmid_dwait", 32'(st_s), 32'd3);
    rst = 1'b1;
    bus_s.bus_ack_i = 1'b1; bus_s.bus_rdata_i = 32'hDEADBEEF;
    tick();
    rst = 1'b0;
    bus_s.bus_ack_i = 1'b0;
    chk("rstmid_state", 32'(st_s), 32'd0);
    chk("rstmid_req", 32'(bus_s.bus_req_o), 32'd0);
    chk("rstmid_valid", 32'(lv_s), 32'd0);
    chk("rstmid_regdata", rdo_s, 32'h0);
    chk("rstmid_fault", 32'(flt_s), 32'd0);
    tick();
    chk("rstmid_valid_after", 32'(lv_s), 32'd0);

    // Split disabled: misaligned sw faults with no bus access
    bus_n.bus_ack_i = 1'b1; bus_n.bus_rdata_i = 32'h00000013;
    tick();
    bus_n.bus_ack_i = 1'b0;
    chk("nsplit_data", 32'(st_n), 32'd2);
    memWrite = 1'b1; memOp = 4'd8; ALU_address = 32'h206; regData_i = 32'hAABBCCDD;
    tick();
    memWrite = 1'b0;
    chk("nsplit_state", 32'(st_n), 32'd0);
    chk("nsplit_no_req", 32'(bus_n.bus_req_o), 32'd0);
    chk("nsplit_fault", 32'(flt_n), 32'd1);
    chk("nsplit_fcode", 32'(fc_n), 32'd1);
    tick();
    chk("nsplit_fetch_rwi", 32'(bus_n.bus_rwi_o), 32'd3);
    chk("nsplit_fault_pulse", 32'(flt_n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
